// File: rtl/spi_master_param.sv
// Parametrised SPI master: configurable word width, all four CPOL/CPHA modes,
// programmable SCLK divider, multiple chip selects and chip-select-held bursts.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DIV_W-1:0]  CFG_DIV,
  input  logic              CFG_CPOL,
  input  logic              CFG_CPHA,
  input  logic              W_STB,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic [CS_W-1:0]   W_CS,
  input  logic              W_LAST,
  output logic              W_READY,
  output logic              R_STB,
  output logic [DATA_W-1:0] R_DATA,
  output logic              BUSY,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SCLK,
  output logic [NUM_CS-1:0] CS_N
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_END} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              last_q, last_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rstb_q, rstb_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;

  logic [NUM_CS-1:0] cs_sel_n;
  logic              tick;
  logic              leading;
  logic              final_edge;
  logic              sample;
  logic [DATA_W-1:0] rx_shift;

  // Out-of-range indices match no bit, so the frame runs with all selects high.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
      assign cs_sel_n[gi] = (W_CS != CS_W'(gi));
    end
  endgenerate

  assign tick       = (cnt_q == '0);
  assign leading    = ~edge_q[0];
  assign final_edge = (edge_q == LAST_EDGE);
  assign sample     = (edge_q[0] == cpha_q);
  assign rx_shift   = {rx_q[DATA_W-2:0], MISO};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      last_q  <= 1'b0;
      edge_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      rstb_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      last_q  <= last_d;
      edge_q  <= edge_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rstb_q  <= rstb_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    last_d  = last_q;
    edge_d  = edge_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rstb_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = CFG_CPOL;
        mosi_d = 1'b1;
        cs_n_d = '1;
        cnt_d  = CFG_DIV;
        if (W_STB) begin
          div_d   = CFG_DIV;
          cpol_d  = CFG_CPOL;
          cpha_d  = CFG_CPHA;
          last_d  = W_LAST;
          tx_d    = W_DATA;
          edge_d  = '0;
          cs_n_d  = cs_sel_n;
          mosi_d  = CFG_CPHA ? 1'b1 : W_DATA[DATA_W-1];
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (tick) begin
          cnt_d   = div_q;
          state_d = S_XFER;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_XFER: begin
        if (tick) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + 1'b1;
          if (sample) begin
            rx_d = rx_shift;
          end
          // CPHA=0 presents the MSB before the first edge, so it shifts on trailing edges.
          if (!cpha_q && !leading && !final_edge) begin
            mosi_d = tx_q[DATA_W-2];
            tx_d   = tx_q << 1;
          end
          if (cpha_q && leading) begin
            mosi_d = tx_q[DATA_W-1];
            tx_d   = tx_q << 1;
          end
          if (final_edge) begin
            edge_d  = '0;
            rdata_d = sample ? rx_shift : rx_q;
            rstb_d  = 1'b1;
            state_d = last_q ? S_END : S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        cnt_d = div_q;
        if (W_STB) begin
          tx_d    = W_DATA;
          last_d  = W_LAST;
          edge_d  = '0;
          if (!cpha_q) begin
            mosi_d = W_DATA[DATA_W-1];
          end
          state_d = S_XFER;
        end
      end

      S_END: begin
        if (tick) begin
          cnt_d   = div_q;
          cs_n_d  = '1;
          mosi_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign W_READY = (state_q == S_IDLE) || (state_q == S_HOLD);
  assign BUSY    = (state_q != S_IDLE);
  assign R_STB   = rstb_q;
  assign R_DATA  = rdata_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign CS_N    = cs_n_q;

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the tester module: a generalised successor of the team's 8-bit byte-strobe SPI controller. Adds configurable word width, all four SPI modes (CPOL/CPHA), an internal programmable SCLK divider, multiple chip selects and multi-word bursts with chip select held between words. Sits between the command/byte-stream logic (strobe/ready handshake) and the external SPI pins.

## Interface
- DATA_W, 8, bits per word, shifted MSB first; legal 4..32
- NUM_CS, 2, number of chip-select outputs; legal 1..8
- DIV_W, 8, width of the divider configuration
- CS_W, NUM_CS>1 ? $clog2(NUM_CS) : 1, width of the chip-select index (derived, do not override)

- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- CFG_DIV  in  DIV_W  SCLK half-period minus 1, in CLK cycles
- CFG_CPOL  in  1  SCLK idle level
- CFG_CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge
- W_STB  in  1  word write strobe, one cycle
- W_DATA  in  DATA_W  word to transmit
- W_CS  in  CS_W  chip-select index, used only on the first word of a frame
- W_LAST  in  1  1: release chip select after this word
- W_READY  out  1  a word can be accepted this cycle
- R_STB  out  1  one-cycle pulse: R_DATA holds a new received word
- R_DATA  out  DATA_W  last received word, held until the next R_STB
- BUSY  out  1  high whenever the FSM is not in IDLE
- MOSI  out  1  serial data out
- MISO  in  1  serial data in
- SCLK  out  1  serial clock
- CS_N  out  NUM_CS  chip selects, active-low

## Operation
- States: IDLE, SETUP, XFER, HOLD, END.
- Half-period tick: down-counter reloads with the latched divider value; tick when it reaches 0. Counter is held reloaded in IDLE and HOLD.
- IDLE: SCLK = CFG_CPOL (registered each cycle); MOSI = 1; CS_N all 1; W_READY = 1.
- W_STB in IDLE:
  - Latch CFG_DIV, CFG_CPOL, CFG_CPHA, W_CS, W_DATA and W_LAST.
  - Assert CS_N[W_CS] = 0 and go to SETUP.
  - Configuration stays frozen until the FSM returns to IDLE.
  - A W_CS value >= NUM_CS selects no chip select; the transfer still runs.
- SETUP: lasts one half-period, then XFER. With CPHA=0, MOSI = W_DATA MSB from SETUP entry.
- XFER: 2*DATA_W half-periods; SCLK toggles on every tick.
  - CPHA=0: sample MISO on the leading edge; shift MOSI on the trailing edge, except the final trailing edge.
  - CPHA=1: drive MOSI on the leading edge; sample MISO on the trailing edge.
  - After the final edge: R_DATA takes the shift register value, R_STB pulses, SCLK is back at CPOL.
  - Next state is END if W_LAST was latched as 1, otherwise HOLD.
- HOLD: CS stays asserted, SCLK idle, W_READY = 1.
  - W_STB latches the new W_DATA and W_LAST and goes directly to XFER; no SETUP, W_CS ignored.
  - HOLD has no timeout.
- END: one half-period of CS hold time, then CS_N all 1, MOSI = 1, back to IDLE.
- W_STB while W_READY = 0 is ignored; no error flag.
- Received word bit order: first sampled bit is R_DATA[DATA_W-1].

## Timing
- Reset values: SCLK 0, MOSI 1, CS_N all 1, W_READY 1, R_STB 0, R_DATA 0, BUSY 0, state IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); the partial word is discarded with no R_STB.
- With D = CFG_DIV + 1, a single-word frame (W_LAST = 1), counted from the cycle after W_STB:
  - SETUP: D cycles.
  - XFER: 2*DATA_W*D cycles.
  - R_STB: in the cycle after the final edge.
  - END: D cycles.
  - W_READY high again: the cycle after END completes.
- Minimum SCLK period is 2 CLK cycles (CFG_DIV = 0).
- In a burst, back-to-back words have zero idle half-periods if W_STB arrives in the first HOLD cycle. The first HOLD cycle is the cycle R_STB is high.
- W_READY is combinational from state: 1 in IDLE and HOLD only.

## Test plan
- Mode 0, DATA_W = 8, CFG_DIV = 1, MISO looped to MOSI, W_DATA = 0xA5, W_CS = 0, W_LAST = 1 -> required response:
  - exactly 8 rising SCLK edges;
  - CS_N = 2'b10 for 36 cycles;
  - R_STB once, R_DATA = 0xA5.
- Mode 3 (CPOL = 1, CPHA = 1), slave model returns 0x3C, W_CS = 1 -> required response:
  - SCLK idles high;
  - MOSI changes on falling edges;
  - R_DATA = 0x3C;
  - CS_N[1] low only.
- Burst: 0x11 (W_LAST = 0) then 0x22 (W_LAST = 1) issued in the R_STB cycle -> required response:
  - CS_N stays low across both words;
  - 16 SCLK pulses total;
  - two R_STB pulses.
- W_STB with 0xFF during XFER of 0x00 -> required response: ignored; MOSI stays 0 for the whole word; only one R_STB.
- RST asserted after the 3rd SCLK edge -> required response:
  - same cycle: SCLK = 0, CS_N all 1, MOSI = 1;
  - no R_STB;
  - the next frame completes normally.
- DATA_W = 16, NUM_CS = 4, CFG_DIV = 0, W_DATA = 0xBEEF looped back -> required response:
  - SCLK = CLK/2;
  - R_DATA = 0xBEEF;
  - CS_N = 4'b1011 when W_CS = 2.
